mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control unit that sits directly upstream of the 16-bit-instruction / 8-bit-data datapath and drives all of its control inputs. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states. It handshakes with instruction and data memories that may insert wait states, and gates PC updates with a write enable. It also counts retired instructions and traps on memory timeouts, illegal opcodes and HALT.

## Interface
Parameters:
- MEM_TIMEOUT, 15: number of consecutive not-ready cycles in FETCH or MEM before entering FAULT (legal range 2..255).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- instr  in  16  instruction word from instruction memory; sampled only in the FETCH cycle where imem_ready=1.
- zero  in  1  ALU zero flag from the datapath.
- imem_ready  in  1  instruction memory has valid instr this cycle.
- dmem_ready  in  1  data memory has completed the access this cycle.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data access request.
- memwrite  out  1  data access is a store; valid while dmem_req=1.
- pcwrite  out  1  PC register load enable.
- pcsrc, jump, alusrc, regdst, memtoreg, regwrite  out  1 each  datapath controls.
- alucontrol  out  3  ALU operation.
- instret  out  16  retired-instruction count; wraps 0xFFFF→0x0000.
- halted  out  1  HALT executed.
- fault  out  1  memory timeout occurred.
- illegal  out  1  one-cycle pulse in DECODE when the opcode is undefined.

## Operation
- Opcode is instr[15:12]. The controller latches instr[15:9] into an internal IR field at the end of FETCH.
- Opcodes:
  - 0x0 RTYPE: alucontrol=IR[11:9], regdst=1, regwrite in WB.
  - 0x1 ADDI: alusrc=1, ALU add (010), regwrite in WB.
  - 0x2 LB: alusrc=1, add, read access in MEM, then memtoreg=1 and regwrite in WB.
  - 0x3 SB: alusrc=1, add, memwrite=1 in MEM.
  - 0x4 BEQ: ALU sub (110); in EXEC, pcsrc=zero and pcwrite=1.
  - 0x5 J: in EXEC, jump=1 and pcwrite=1.
  - 0xF HALT: enters HALT.
  - Any other opcode: illegal pulse, retires as a NOP via WB with regwrite=0.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT. Encoding is binary (3 bits).
- FETCH: imem_req=1. On imem_ready=1, latch IR and go to DECODE; otherwise stay.
- DECODE: always 1 cycle. Goes to HALT for opcode 0xF, otherwise to EXEC.
- EXEC:
  - ALU controls driven.
  - BEQ and J finish here: pcwrite=1, instret increments, go to FETCH.
  - LB and SB go to MEM.
  - All other opcodes go to WB.
- MEM: dmem_req=1 (memwrite=1 for SB), with ALU controls held.
  - On dmem_ready=1: SB finishes (pcwrite=1, instret increments, go to FETCH); LB goes to WB.
- WB: regwrite per opcode, pcwrite=1 with pcsrc=0 and jump=0 (PC+2), instret increments, go to FETCH.
- HALT and FAULT: absorbing states. All controls are 0; halted or fault is held at 1. Only reset leaves them.
- Timeout:
  - wait_cnt clears on entry to FETCH and to MEM.
  - Each cycle ready is low, wait_cnt increments.
  - If wait_cnt==MEM_TIMEOUT-1 and ready is low, next state is FAULT.
  - ready=1 in the same cycle takes priority over the timeout.
- Outputs are Moore functions of state and the latched IR. Every control not listed for a state is 0.

## Timing
- Reset: on the next clk edge with reset=1, state=FETCH, IR=0, wait_cnt=0, instret=0, halted=0, fault=0.
  - All outputs read 0 in the reset cycle and the following FETCH cycle, except imem_req=1 in FETCH.
  - Reset mid-access drops dmem_req with no completion. Reset has priority over every transition.
- Minimum cycles per instruction, with ready high on the first request cycle:
  - BEQ and J: 3.
  - RTYPE, ADDI and illegal opcodes: 4.
  - SB: 4.
  - LB: 5.
- Each wait cycle adds one cycle.
- pcwrite is exactly one cycle per retired instruction, coincident with the instret increment, which becomes visible the next cycle.
- Requests: dmem_req and imem_req hold high until the matching ready is sampled high. They are low the cycle after that.
- The ready inputs are ignored outside their request states.

## Structure
- Shared package mc_pkg holds:
  - opcode constants OP_RTYPE…OP_HALT;
  - state enum;
  - ALU codes ALU_ADD=3'b010 and ALU_SUB=3'b110, which must match the ALU.
- Sub-module mc_decode: purely combinational, maps state, IR and zero to the control bundle. The mc_controller top holds the state register, IR, wait_cnt and instret.

## Test plan
- RTYPE 0x0A05 (IR[11:9]=101), both ready tied high → FETCH/DECODE/EXEC/WB over 4 cycles; alucontrol=101 and regdst=1 in EXEC and WB; regwrite and pcwrite in WB only; instret 0→1.
- LB 0x2xxx with dmem_ready low for 3 MEM cycles → dmem_req high for 4 cycles, memwrite=0; memtoreg=1 and regwrite in WB; 8 cycles total.
- BEQ with zero=1, then BEQ with zero=0 → each takes 3 cycles; pcsrc=1 and pcsrc=0 respectively alongside pcwrite in EXEC.
- imem_ready held low with MEM_TIMEOUT=15 → FAULT after the 15th low cycle, fault=1 held, imem_req=0. Repeat with ready rising in the 15th cycle → no fault.
- HALT 0xF000, then illegal 0x7000 after reset → HALT state with halted=1 and no pcwrite; illegal pulses in DECODE and instret increments in WB.
- Assert reset during MEM of an SB → next cycle dmem_req=0, state FETCH, instret=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle control unit.
// The ALU operation codes must match the datapath ALU.
package mc_pkg;

  localparam int unsigned IR_W      = 7;
  localparam int unsigned OP_W      = 4;
  localparam int unsigned ALU_W     = 3;
  localparam int unsigned WAIT_W    = 8;
  localparam int unsigned INSTRET_W = 16;

  localparam logic [OP_W-1:0] OP_RTYPE = 4'h0;
  localparam logic [OP_W-1:0] OP_ADDI  = 4'h1;
  localparam logic [OP_W-1:0] OP_LB    = 4'h2;
  localparam logic [OP_W-1:0] OP_SB    = 4'h3;
  localparam logic [OP_W-1:0] OP_BEQ   = 4'h4;
  localparam logic [OP_W-1:0] OP_J     = 4'h5;
  localparam logic [OP_W-1:0] OP_HALT  = 4'hF;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  typedef struct packed {
    logic             imem_req;
    logic             dmem_req;
    logic             memwrite;
    logic             pcwrite;
    logic             pcsrc;
    logic             jump;
    logic             alusrc;
    logic             regdst;
    logic             memtoreg;
    logic             regwrite;
    logic [ALU_W-1:0] alucontrol;
    logic             halted;
    logic             fault;
    logic             illegal;
  } ctrl_t;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_ADDI, OP_LB, OP_SB, OP_BEQ, OP_J, OP_HALT: ok = 1'b1;
      default:                                                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational control decode: state, latched IR and ALU flag to the
// datapath control bundle. SB retirement in MEM depends on dmem_ready.
module mc_decode
  import mc_pkg::*;
(
  input  state_t          state,
  input  logic [IR_W-1:0] ir,
  input  logic            zero,
  input  logic            dmem_ready,
  output ctrl_t           ctrl_c
);

  logic [OP_W-1:0]  op;
  logic [ALU_W-1:0] funct;
  logic             alusrc_c;
  logic             regdst_c;
  logic [ALU_W-1:0] alu_c;

  assign op    = ir[IR_W-1 -: OP_W];
  assign funct = ir[ALU_W-1:0];

  // ALU-side controls held for the opcode through EXEC, MEM and WB
  always_comb begin
    alusrc_c = 1'b0;
    regdst_c = 1'b0;
    alu_c    = '0;
    case (op)
      OP_RTYPE: begin
        regdst_c = 1'b1;
        alu_c    = funct;
      end
      OP_ADDI, OP_LB, OP_SB: begin
        alusrc_c = 1'b1;
        alu_c    = ALU_ADD;
      end
      OP_BEQ:  alu_c = ALU_SUB;
      default: ;
    endcase
  end

  always_comb begin
    ctrl_c = '0;
    case (state)
      S_FETCH:  ctrl_c.imem_req = 1'b1;
      S_DECODE: ctrl_c.illegal  = ~op_legal(op);
      S_EXEC: begin
        ctrl_c.alusrc     = alusrc_c;
        ctrl_c.regdst     = regdst_c;
        ctrl_c.alucontrol = alu_c;
        if (op == OP_BEQ) begin
          ctrl_c.pcwrite = 1'b1;
          ctrl_c.pcsrc   = zero;
        end
        if (op == OP_J) begin
          ctrl_c.pcwrite = 1'b1;
          ctrl_c.jump    = 1'b1;
        end
      end
      S_MEM: begin
        ctrl_c.alusrc     = alusrc_c;
        ctrl_c.regdst     = regdst_c;
        ctrl_c.alucontrol = alu_c;
        ctrl_c.dmem_req   = 1'b1;
        ctrl_c.memwrite   = (op == OP_SB);
        ctrl_c.pcwrite    = (op == OP_SB) && dmem_ready;
      end
      S_WB: begin
        ctrl_c.alusrc     = alusrc_c;
        ctrl_c.regdst     = regdst_c;
        ctrl_c.alucontrol = alu_c;
        ctrl_c.pcwrite    = 1'b1;
        ctrl_c.regwrite   = (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LB);
        ctrl_c.memtoreg   = (op == OP_LB);
      end
      S_HALT:  ctrl_c.halted = 1'b1;
      S_FAULT: ctrl_c.fault  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle controller: sequences FETCH/DECODE/EXEC/MEM/WB, handshakes with
// wait-state memories, counts retired instructions and traps on timeout/HALT.
module mc_controller
  import mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          instr,
  input  logic                 zero,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 memwrite,
  output logic                 pcwrite,
  output logic                 pcsrc,
  output logic                 jump,
  output logic                 alusrc,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic [ALU_W-1:0]     alucontrol,
  output logic [INSTRET_W-1:0] instret,
  output logic                 halted,
  output logic                 fault,
  output logic                 illegal
);

  state_t            state;
  state_t            state_next;
  logic [IR_W-1:0]   ir;
  logic [WAIT_W-1:0] wait_cnt;
  logic [OP_W-1:0]   op;
  logic              timeout_c;
  ctrl_t             ctrl_c;
  ctrl_t             ctrl_out_c;
  logic              instr_unused_c;

  assign op             = ir[IR_W-1 -: OP_W];
  assign timeout_c      = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
  assign instr_unused_c = ^instr[8:0];

  mc_decode u_decode (
    .state      (state),
    .ir         (ir),
    .zero       (zero),
    .dmem_ready (dmem_ready),
    .ctrl_c     (ctrl_c)
  );

  // Next-state logic; ready in the same cycle wins over the timeout
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (imem_ready)     state_next = S_DECODE;
        else if (timeout_c) state_next = S_FAULT;
      end
      S_DECODE: state_next = (op == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        if ((op == OP_BEQ) || (op == OP_J))     state_next = S_FETCH;
        else if ((op == OP_LB) || (op == OP_SB)) state_next = S_MEM;
        else                                     state_next = S_WB;
      end
      S_MEM: begin
        if (dmem_ready)     state_next = (op == OP_SB) ? S_FETCH : S_WB;
        else if (timeout_c) state_next = S_FAULT;
      end
      S_WB:    state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      ir       <= '0;
      wait_cnt <= '0;
      instret  <= '0;
    end else begin
      state <= state_next;
      if ((state == S_FETCH) && imem_ready) ir <= instr[15:9];
      // wait counter restarts on every state change, so it is clear on entry
      if (state_next != state) wait_cnt <= '0;
      else if ((state == S_FETCH) || (state == S_MEM)) wait_cnt <= wait_cnt + WAIT_W'(1);
      if (ctrl_c.pcwrite) instret <= instret + INSTRET_W'(1);
    end
  end

  // Controls are forced low while reset is asserted
  assign ctrl_out_c = reset ? ctrl_t'('0) : ctrl_c;

  assign imem_req   = ctrl_out_c.imem_req;
  assign dmem_req   = ctrl_out_c.dmem_req;
  assign memwrite   = ctrl_out_c.memwrite;
  assign pcwrite    = ctrl_out_c.pcwrite;
  assign pcsrc      = ctrl_out_c.pcsrc;
  assign jump       = ctrl_out_c.jump;
  assign alusrc     = ctrl_out_c.alusrc;
  assign regdst     = ctrl_out_c.regdst;
  assign memtoreg   = ctrl_out_c.memtoreg;
  assign regwrite   = ctrl_out_c.regwrite;
  assign alucontrol = ctrl_out_c.alucontrol;
  assign halted     = ctrl_out_c.halted;
  assign fault      = ctrl_out_c.fault;
  assign illegal    = ctrl_out_c.illegal;

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller: per-cycle control bundle
// and retired-instruction count against hand-computed values.
module tb_mc_controller;

  localparam logic [15:0] B_IREQ   = 16'h8000;
  localparam logic [15:0] B_DREQ   = 16'h4000;
  localparam logic [15:0] B_MW     = 16'h2000;
  localparam logic [15:0] B_PCW    = 16'h1000;
  localparam logic [15:0] B_PCSRC  = 16'h0800;
  localparam logic [15:0] B_JUMP   = 16'h0400;
  localparam logic [15:0] B_ALUSRC = 16'h0200;
  localparam logic [15:0] B_REGDST = 16'h0100;
  localparam logic [15:0] B_M2R    = 16'h0080;
  localparam logic [15:0] B_RW     = 16'h0040;
  localparam logic [15:0] A2       = 16'h0010;
  localparam logic [15:0] A5       = 16'h0028;
  localparam logic [15:0] A6       = 16'h0030;
  localparam logic [15:0] B_HALT   = 16'h0004;
  localparam logic [15:0] B_FAULT  = 16'h0002;
  localparam logic [15:0] B_ILL    = 16'h0001;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        zero;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req, dmem_req, memwrite, pcwrite, pcsrc, jump;
  logic        alusrc, regdst, memtoreg, regwrite;
  logic [2:0]  alucontrol;
  logic [15:0] instret;
  logic        halted, fault, illegal;
  logic [15:0] ctl;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign ctl = {imem_req, dmem_req, memwrite, pcwrite, pcsrc, jump, alusrc,
                regdst, memtoreg, regwrite, alucontrol, halted, fault, illegal};

  mc_controller #(.MEM_TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .zero       (zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .memwrite   (memwrite),
    .pcwrite    (pcwrite),
    .pcsrc      (pcsrc),
    .jump       (jump),
    .alusrc     (alusrc),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alucontrol (alucontrol),
    .instret    (instret),
    .halted     (halted),
    .fault      (fault),
    .illegal    (illegal)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the control bundle for the current cycle, then advance one clock
  task automatic cyc(input string tag, input logic [15:0] exp);
    #1;
    chk(tag, ctl, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic chki(input string tag, input logic [15:0] exp);
    chk(tag, instret, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; instr = 16'h0000; zero = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    @(posedge clk); #1;
    chki("rst_instret", 16'd0);
    cyc("rst_ctl", 16'h0000);
    reset = 1'b0;

    // RTYPE, both readies high: 4 cycles
    instr = 16'h0A05; imem_ready = 1'b1; dmem_ready = 1'b1;
    cyc("rt_fetch", B_IREQ);
    cyc("rt_decode", 16'h0000);
    cyc("rt_exec", B_REGDST | A5);
    chki("rt_instret_pre", 16'd0);
    cyc("rt_wb", B_PCW | B_REGDST | B_RW | A5);
    chki("rt_instret", 16'd1);

    // LB with three data wait cycles: 8 cycles
    instr = 16'h2345; dmem_ready = 1'b0;
    cyc("lb_fetch", B_IREQ);
    cyc("lb_decode", 16'h0000);
    cyc("lb_exec", B_ALUSRC | A2);
    repeat (3) cyc("lb_mem_wait", B_DREQ | B_ALUSRC | A2);
    dmem_ready = 1'b1;
    cyc("lb_mem_done", B_DREQ | B_ALUSRC | A2);
    cyc("lb_wb", B_PCW | B_ALUSRC | A2 | B_M2R | B_RW);
    chki("lb_instret", 16'd2);

    // BEQ taken then not taken: 3 cycles each
    instr = 16'h4000; zero = 1'b1;
    cyc("beq1_fetch", B_IREQ);
    cyc("beq1_decode", 16'h0000);
    cyc("beq1_exec", B_PCW | B_PCSRC | A6);
    chki("beq1_instret", 16'd3);
    zero = 1'b0;
    cyc("beq0_fetch", B_IREQ);
    cyc("beq0_decode", 16'h0000);
    cyc("beq0_exec", B_PCW | A6);
    chki("beq0_instret", 16'd4);

    // J: 3 cycles
    instr = 16'h5000;
    cyc("j_fetch", B_IREQ);
    cyc("j_decode", 16'h0000);
    cyc("j_exec", B_PCW | B_JUMP);
    chki("j_instret", 16'd5);

    // SB, data ready immediately: 4 cycles
    instr = 16'h3000;
    cyc("sb_fetch", B_IREQ);
    cyc("sb_decode", 16'h0000);
    cyc("sb_exec", B_ALUSRC | A2);
    cyc("sb_mem", B_DREQ | B_MW | B_ALUSRC | A2 | B_PCW);
    chki("sb_instret", 16'd6);

    // Reset in the middle of an SB data access
    dmem_ready = 1'b0;
    cyc("sbr_fetch", B_IREQ);
    cyc("sbr_decode", 16'h0000);
    cyc("sbr_exec", B_ALUSRC | A2);
    cyc("sbr_mem", B_DREQ | B_MW | B_ALUSRC | A2);
    reset = 1'b1;
    cyc("sbr_rst_cycle", 16'h0000);
    reset = 1'b0; imem_ready = 1'b0;
    chki("sbr_instret", 16'd0);

    // Fetch timeout: 15 consecutive not-ready cycles then FAULT
    cyc("to_wait1", B_IREQ);
    repeat (14) cyc("to_wait", B_IREQ);
    imem_ready = 1'b1;
    cyc("to_fault", B_FAULT);
    cyc("to_fault_hold", B_FAULT);
    chki("to_instret", 16'd0);

    // Ready rising in the 15th cycle beats the timeout
    reset = 1'b1; imem_ready = 1'b0;
    cyc("nt_rst", 16'h0000);
    reset = 1'b0;
    repeat (14) cyc("nt_wait", B_IREQ);
    imem_ready = 1'b1; instr = 16'h5000;
    cyc("nt_ready15", B_IREQ);
    cyc("nt_decode", 16'h0000);
    cyc("nt_exec", B_PCW | B_JUMP);
    chki("nt_instret", 16'd1);

    // HALT is absorbing, no pcwrite
    reset = 1'b1;
    cyc("h_rst", 16'h0000);
    reset = 1'b0; instr = 16'hF000;
    cyc("h_fetch", B_IREQ);
    cyc("h_decode", 16'h0000);
    repeat (3) cyc("h_hold", B_HALT);
    chki("h_instret", 16'd0);

    // Illegal opcode retires as a NOP through WB
    reset = 1'b1;
    cyc("il_rst", 16'h0000);
    reset = 1'b0; instr = 16'h7000;
    cyc("il_fetch", B_IREQ);
    cyc("il_decode", B_ILL);
    cyc("il_exec", 16'h0000);
    cyc("il_wb", B_PCW);
    chki("il_instret", 16'd1);
    imem_ready = 1'b0;
    cyc("il_next_fetch", B_IREQ);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
